alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU; successor to the single-cycle combinational ALU.
//  - Adds a valid/ready handshake and registered results with Ze/N/V/C flags.
//  - Adds logic and shift ops plus iterative MUL/DIVU/REMU.
//  - Sits between decode/register-read and writeback; stalls the pipeline via in_ready/out_valid.

---
 rtl/alu_mc.sv | 218 +++++++++++++++++++++
 tb/tb_alu_mc.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and registered result/flags
// ALU_MULDIV_EN adds iterative MUL/DIVU/REMU; without it those opcodes report illegal.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Ze,
  output logic             N,
  output logic             V,
  output logic             C,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_REMU = 4'b1100;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MULDIV_EN
    , S_BUSY = 2'd2
`endif
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] fast_res;
  logic             fast_c;
  logic             fast_v;
  logic             fast_ill;
  logic             is_iter;
  logic [WIDTH:0]   sum;

  // Single-cycle datapath, evaluated straight from the inputs in IDLE
  always_comb begin
    fast_res = '0;
    fast_c   = 1'b0;
    fast_v   = 1'b0;
    fast_ill = 1'b0;
    is_iter  = 1'b0;
    sum      = '0;
    case (ALUControl)
      OP_ADD: begin
        sum      = {1'b0, A} + {1'b0, B};
        fast_res = sum[WIDTH-1:0];
        fast_c   = sum[WIDTH];
        fast_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sum      = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        fast_res = sum[WIDTH-1:0];
        fast_c   = sum[WIDTH];
        fast_v   = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  fast_res = A & B;
      OP_OR:   fast_res = A | B;
      OP_XOR:  fast_res = A ^ B;
      OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: fast_res = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  fast_res = A << B[SHW-1:0];
      OP_SRL:  fast_res = A >> B[SHW-1:0];
      OP_SRA:  fast_res = $signed(A) >>> B[SHW-1:0];
`ifdef ALU_MULDIV_EN
      OP_MUL, OP_DIVU, OP_REMU: is_iter = 1'b1;
`endif
      default: fast_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // acc: partial product / partial remainder; x: multiplicand / quotient; y: multiplier / divisor
  logic [WIDTH-1:0] acc, x, y;
  logic [WIDTH-1:0] acc_nx, x_nx, y_nx;
  logic [WIDTH-1:0] iter_res;
  logic [WIDTH:0]   rem_sh;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt;

  always_comb begin
    acc_nx   = acc;
    x_nx     = x;
    y_nx     = y;
    iter_res = '0;
    rem_sh   = {acc, x[WIDTH-1]};
    if (op_q == OP_MUL) begin
      if (y[0]) acc_nx = acc + x;
      x_nx     = x << 1;
      y_nx     = y >> 1;
      iter_res = acc_nx;
    end else begin
      // Divide by zero falls out naturally: every step subtracts, quotient all-ones, remainder A
      if (rem_sh >= {1'b0, y}) begin
        acc_nx = WIDTH'(rem_sh - {1'b0, y});
        x_nx   = {x[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[WIDTH-1:0];
        x_nx   = {x[WIDTH-2:0], 1'b0};
      end
      iter_res = (op_q == OP_DIVU) ? x_nx : acc_nx;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
`ifdef ALU_MULDIV_EN
          state_next = is_iter ? S_BUSY : S_DONE;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef ALU_MULDIV_EN
      S_BUSY: begin
        if (cnt == '0) state_next = S_DONE;
      end
`endif
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Result  <= '0;
      Ze      <= 1'b1;
      N       <= 1'b0;
      V       <= 1'b0;
      C       <= 1'b0;
      illegal <= 1'b0;
`ifdef ALU_MULDIV_EN
      acc     <= '0;
      x       <= '0;
      y       <= '0;
      op_q    <= '0;
      cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid && !is_iter) begin
            Result  <= fast_res;
            Ze      <= (fast_res == '0);
            N       <= fast_res[WIDTH-1];
            V       <= fast_v;
            C       <= fast_c;
            illegal <= fast_ill;
          end
`ifdef ALU_MULDIV_EN
          if (in_valid && is_iter) begin
            acc  <= '0;
            x    <= A;
            y    <= B;
            op_q <= ALUControl;
            cnt  <= SHW'(WIDTH - 1);
          end
`endif
        end
`ifdef ALU_MULDIV_EN
        S_BUSY: begin
          acc <= acc_nx;
          x   <= x_nx;
          y   <= y_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            Result  <= iter_res;
            Ze      <= (iter_res == '0);
            N       <= iter_res[WIDTH-1];
            V       <= 1'b0;
            C       <= 1'b0;
            illegal <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (WIDTH=32), honours ALU_MULDIV_EN
module tb_alu_mc;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, Result;
  logic [3:0]   ALUControl;
  logic         Ze, N, V, C, illegal;

  int checks = 0;
  int errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
    .out_ready(out_ready), .Result(Result), .Ze(Ze), .N(N), .V(V), .C(C),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic bit is_iter_op(input logic [3:0] op);
`ifdef ALU_MULDIV_EN
    return (op == 4'd10) || (op == 4'd11) || (op == 4'd12);
`else
    return 1'b0;
`endif
  endfunction

  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic ill, output logic c,
                                output logic v);
    longint      s;
    longint      lim_hi;
    longint      lim_lo;
    logic [63:0] u;
    lim_hi = 2147483647;
    lim_lo = -lim_hi - 1;
    r = '0; ill = 1'b0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: begin
        u = 64'(a) + 64'(b);
        r = u[W-1:0];
        c = (u > 64'hFFFF_FFFF);
        s = longint'($signed(a)) + longint'($signed(b));
        v = (s > lim_hi) || (s < lim_lo);
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
        s = longint'($signed(a)) - longint'($signed(b));
        v = (s > lim_hi) || (s < lim_lo);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
      4'd6: r = (a < b) ? 1 : 0;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: r = $signed(a) >>> b[4:0];
`ifdef ALU_MULDIV_EN
      4'd10: begin u = 64'(a) * 64'(b); r = u[W-1:0]; end
      4'd11: r = (b == 0) ? '1 : a / b;
      4'd12: r = (b == 0) ? a : a % b;
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  // Issue one op from a negedge; returns negedges from accept edge until out_valid (200 = timeout)
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    ALUControl = op; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A = $urandom; B = $urandom; ALUControl = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; ALUControl = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, Result, Ze, N, V, C, illegal} !== {1'b1, 1'b0, 32'h0, 5'b10000}) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h flags=%b%b%b%b%b", in_ready, out_valid,
               Result, Ze, N, V, C, illegal);
    end
    // Abort a MUL in flight
    ALUControl = 4'd10; A = 32'h0000_FFFF; B = 32'h0001_0001; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, Result, Ze, N, V, C, illegal} !== {1'b1, 1'b0, 32'h0, 5'b10000}) begin
      errors++;
      $display("FAIL reset_midop got rdy=%b vld=%b res=%h flags=%b%b%b%b%b", in_ready, out_valid,
               Result, Ze, N, V, C, illegal);
    end
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      errors++;
      $display("FAIL reset_stale got %0d valid cycles required 0", stale);
    end
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [4:0]   f;   // {Ze,N,V,C,illegal}
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t vecs[$];
    int   lat;
    vecs.push_back('{4'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 5'b01100, 1});
    vecs.push_back('{4'd1, 32'h3, 32'h5, 32'hFFFF_FFFE, 5'b01000, 1});
    vecs.push_back('{4'd1, 32'h5, 32'h5, 32'h0, 5'b10010, 1});
    vecs.push_back('{4'd5, 32'h5, 32'hA, 32'h1, 5'b00000, 1});
    vecs.push_back('{4'd6, 32'h5, 32'hFFFF_FFFF, 32'h1, 5'b00000, 1});
    vecs.push_back('{4'd9, 32'hF000_0000, 32'h4, 32'hFF00_0000, 5'b01000, 1});
    vecs.push_back('{4'd7, 32'h1, 32'h24, 32'h10, 5'b00000, 1});
    vecs.push_back('{4'd15, 32'h1234, 32'h5, 32'h0, 5'b10001, 1});
`ifdef ALU_MULDIV_EN
    vecs.push_back('{4'd10, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 5'b01000, W + 1});
    vecs.push_back('{4'd11, 32'd64, 32'd7, 32'd9, 5'b00000, W + 1});
    vecs.push_back('{4'd12, 32'd64, 32'd7, 32'd1, 5'b00000, W + 1});
    vecs.push_back('{4'd11, 32'h1234, 32'h0, 32'hFFFF_FFFF, 5'b01000, W + 1});
    vecs.push_back('{4'd12, 32'h1234, 32'h0, 32'h1234, 5'b00000, W + 1});
`else
    vecs.push_back('{4'd10, 32'h0000_FFFF, 32'h0001_0001, 32'h0, 5'b10001, 1});
    vecs.push_back('{4'd11, 32'd64, 32'd7, 32'h0, 5'b10001, 1});
    vecs.push_back('{4'd12, 32'd64, 32'd7, 32'h0, 5'b10001, 1});
`endif
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      checks++;
      if (lat !== vecs[i].lat) begin
        errors++;
        $display("FAIL directed_lat[%0d] op=%h got %0d required %0d", i, vecs[i].op, lat,
                 vecs[i].lat);
      end
      checks++;
      if ({Result, Ze, N, V, C, illegal} !== {vecs[i].r, vecs[i].f}) begin
        errors++;
        $display("FAIL directed[%0d] op=%h got res=%h f=%b%b%b%b%b required res=%h f=%b", i,
                 vecs[i].op, Result, Ze, N, V, C, illegal, vecs[i].r, vecs[i].f);
      end
      release_op();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corners[6];
    logic [W-1:0] a, b, er;
    logic [3:0]   op;
    logic         ei, ec, ev;
    int           lat, elat;
    corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1F};
    repeat (150) begin
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = a;
      model(op, a, b, er, ei, ec, ev);
      elat = is_iter_op(op) ? W + 1 : 1;
      run_op(op, a, b, lat);
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("FAIL random_lat op=%h got %0d required %0d", op, lat, elat);
      end
      checks++;
      if ({Result, Ze, N, V, C, illegal} !== {er, (er == 0), er[W-1], ev, ec, ei}) begin
        errors++;
        $display("FAIL random op=%h a=%h b=%h got res=%h f=%b%b%b%b%b required res=%h f=%b%b%b%b%b",
                 op, a, b, Result, Ze, N, V, C, illegal, er, (er == 0), er[W-1], ev, ec, ei);
      end
      release_op();
    end
  endtask

  task automatic test_hold();
    int lat;
    run_op(4'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, lat);
    repeat (5) begin
      in_valid = 1'b1; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, Result, Ze} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
        errors++;
        $display("FAIL hold got vld=%b rdy=%b res=%h ze=%b required vld=1 rdy=0 res=0 ze=1",
                 out_valid, in_ready, Result, Ze);
      end
    end
    in_valid = 1'b0;
    release_op();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release got vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] eq[$];
    logic [W-1:0] er, ex;
    logic         ei, ec, ev;
    logic [3:0]   op;
    int           outs;
    outs = 0;
    out_ready = 1'b1;
    op = 4'($urandom_range(0, 9)); A = $urandom; B = $urandom;
    ALUControl = op; in_valid = 1'b1;
    repeat (40) begin
      if (out_valid) begin
        outs++;
        ex = (eq.size() > 0) ? eq.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (Result !== ex) begin
          errors++;
          $display("FAIL b2b_result got %h required %h", Result, ex);
        end
        // inputs are ignored while not ready, so new operands can be set up here
        op = ($urandom_range(0, 10) == 10) ? 4'd15 : 4'($urandom_range(0, 9));
        A = $urandom; B = $urandom; ALUControl = op;
      end
      if (in_ready) begin
        model(ALUControl, A, B, er, ei, ec, ev);
        eq.push_back(er);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (outs !== 20) begin
      errors++;
      $display("FAIL b2b_throughput got %0d results required 20", outs);
    end
    if (out_valid) release_op();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
